johnson_phase_monitor: RTL and testbench
========================================

Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the four-bit Johnson counter and its 4-to-8 one-hot decoder.
- Consumes the 8-bit one-hot phase word and encodes it to a 3-bit phase index.
- Checks each cycle that the phase advanced exactly one position. Acquires and declares lock, then counts completed revolutions and illegal steps for status and debug logic.

Parameters:
- LOCK_CNT, 4, consecutive good steps required in TRACK before declaring lock (range 1..15).
- REV_W, 8, width of the revolution counter; wraps modulo 2^REV_W.
- ERR_W, 8, width of the error counter; saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- phase_in  input  8  one-hot phase word from the decoder. Legal sequence is 0x80,0x40,0x20,0x10,0x08,0x04,0x02,0x01, then 0x80 again. 0x00 means the counter is in an illegal state.
- clr  input  1  synchronous clear of rev_cnt, err_cnt and err_sticky.
- phase_idx  output  3  encoded index: 0x80 gives 0, 0x40 gives 1, through 0x01 giving 7.
- idx_vld  output  1  last sampled phase_in was exactly one-hot.
- locked  output  1  FSM is in LOCKED.
- rev_pulse  output  1  one-cycle pulse per completed revolution while locked.
- rev_cnt  output  REV_W  revolution count.
- err_pulse  output  1  one-cycle pulse on a bad step while locked.
- err_sticky  output  1  set by err_pulse, cleared only by clr or reset.
- err_cnt  output  ERR_W  saturating error count.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=ACQ; internal prev=0x00; good_cnt=0.
  - All outputs are 0, including phase_idx=0 and idx_vld=0.
- Latency: every output is registered and reflects the phase_in sampled at the same rising edge (1-cycle latency). There are no combinational input-to-output paths.
- Definitions:
  - valid: phase_in has exactly one bit set.
  - good step: prev is valid, phase_in is valid, and phase_in equals prev rotated right by one, i.e. {prev[0],prev[7:1]}.
  - prev <= phase_in every cycle.
- Invalid input: phase_idx holds its last value and idx_vld=0. Multi-hot codes such as 0x81 are invalid, not priority-encoded.
- FSM states: ACQ, TRACK, LOCKED.
  - ACQ:
    - valid phase_in: go to TRACK, good_cnt=0.
    - otherwise: stay in ACQ.
  - TRACK:
    - good step: good_cnt+1. If the result equals LOCK_CNT, go to LOCKED.
    - bad step with valid phase_in: stay in TRACK, good_cnt=0.
    - invalid phase_in: go to ACQ.
    - No err_pulse is generated in ACQ or TRACK.
  - LOCKED:
    - good step: stay in LOCKED.
    - any other step: err_pulse=1 for one cycle, err_sticky=1, err_cnt increments (saturating). Next state is TRACK with good_cnt=0 if phase_in is valid, else ACQ.
    - locked deasserts at the same edge that err_pulse asserts.
- Revolutions: rev_pulse=1 and rev_cnt+1 on a good step into 0x80 taken while state is LOCKED. A step that completes lock does not count.
- Hold and duplicate behaviour: there is no enable. A repeated phase (e.g. 0x40,0x40) is a bad step.
- clr:
  - Synchronous; does not affect the FSM, prev or phase_idx.
  - clr with a simultaneous error or revolution event: the counter loads the event value (err_cnt=1 with err_sticky=1, and/or rev_cnt=1).
- Wrap and saturation: rev_cnt wraps from all-ones to 0 silently. err_cnt holds at all-ones; err_pulse and err_sticky still behave normally.
- Reset mid-operation returns to the reset values immediately, and lock must be re-acquired.

Decomposition:
- Shared package johnson_pkg holds:
  - PHASE_W=8
  - PHASE_START=8'h80
  - the state typedef {ACQ,TRACK,LOCKED}
  - a rotate-right helper function
- One sub-module, onehot8_enc: combinational one-hot to index plus valid. Valid means exactly one bit set; index=7-bitpos. It is instantiated once on phase_in.

Test Plan:
- Acquisition (LOCK_CNT=4): drive 0x00 then the legal sequence from 0x80, one word per cycle.
  - idx_vld first rises after 0x80.
  - locked rises after 0x08 is sampled.
  - The next 0x80 gives rev_pulse=1 and rev_cnt=1; err_cnt stays 0.
- Locked error: lock, then inject 0x20 where 0x04 is expected.
  - err_pulse=1 for one cycle; locked=0 at the same edge; err_cnt=1; err_sticky=1.
  - Resuming the legal sequence re-locks after 4 good steps.
- Invalid codes: while locked, drive 0x00, then 0x81.
  - One err_pulse; state goes to ACQ; idx_vld=0; phase_idx holds.
  - The second invalid word produces no further err_pulse.
- Counter boundaries (REV_W=2, ERR_W=2):
  - 5 locked revolutions give rev_cnt 1,2,3,0,1.
  - 4 lock/error cycles give err_cnt 1,2,3,3 with err_pulse still asserted on each error.
- clr collision: assert clr in the same cycle as a locked error → err_cnt=1, err_sticky=1. clr alone → err_cnt=0, err_sticky=0, rev_cnt=0, locked unchanged.
- Async reset: drop rstn mid-sequence between clock edges → all outputs 0 immediately. After release, lock needs LOCK_CNT good steps again.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase monitor: phase word geometry,
// FSM state type and the one-position rotate used to predict the next phase.
package johnson_pkg;

   localparam int PHASE_W = 8;
   localparam logic [PHASE_W-1:0] PHASE_START = 8'h80;

   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [PHASE_W-1:0] rotr1(input logic [PHASE_W-1:0] w);
      return {w[0], w[PHASE_W-1:1]};
   endfunction

endpackage

// File: rtl/onehot8_enc.sv
// One-hot to index encoder: 0x80 maps to 0 and 0x01 maps to 7.
// Multi-hot and all-zero words are flagged invalid rather than priority-encoded.
module onehot8_enc
   import johnson_pkg::*;
(
   input  logic [PHASE_W-1:0] onehot,
   output logic [2:0]         idx,
   output logic               vld
);

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < PHASE_W; i++) begin
         if (onehot[i]) idx = 3'(PHASE_W - 1 - i);
      end
      vld = ($countones(onehot) == 1);
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks the decoded Johnson phase, acquires lock after LOCK_CNT good steps,
// and counts revolutions and illegal steps for status/debug logic.
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int REV_W    = 8,
   parameter int ERR_W    = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               clr,
   output logic [2:0]         phase_idx,
   output logic               idx_vld,
   output logic               locked,
   output logic               rev_pulse,
   output logic [REV_W-1:0]   rev_cnt,
   output logic               err_pulse,
   output logic               err_sticky,
   output logic [ERR_W-1:0]   err_cnt
);

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   state_t             state, state_nxt;
   logic [3:0]         good_cnt, good_cnt_nxt;
   logic [PHASE_W-1:0] prev;
   logic               prev_vld;
   logic [2:0]         in_idx;
   logic               in_vld;
   logic               good_step;
   logic               rev_ev, err_ev;

   onehot8_enc u_enc (
      .onehot (phase_in),
      .idx    (in_idx),
      .vld    (in_vld)
   );

   assign good_step = prev_vld && in_vld && (phase_in == rotr1(prev));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ACQ;
         good_cnt <= 4'd0;
         prev     <= '0;
         prev_vld <= 1'b0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
         prev     <= phase_in;
         prev_vld <= in_vld;
      end
   end

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = 4'd0;
      rev_ev       = 1'b0;
      err_ev       = 1'b0;
      unique case (state)
         ACQ: begin
            if (in_vld) state_nxt = TRACK;
         end
         TRACK: begin
            if (good_step) begin
               good_cnt_nxt = good_cnt + 4'd1;
               if (good_cnt + 4'd1 == LOCK_TGT) begin
                  state_nxt    = LOCKED;
                  good_cnt_nxt = 4'd0;
               end
            end else if (!in_vld) begin
               state_nxt = ACQ;
            end
         end
         LOCKED: begin
            if (good_step) begin
               rev_ev = (phase_in == PHASE_START);
            end else begin
               err_ev    = 1'b1;
               state_nxt = in_vld ? TRACK : ACQ;
            end
         end
         default: state_nxt = ACQ;
      endcase
   end

   assign locked = (state == LOCKED);

   // clr coinciding with an event loads the event value instead of zero
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_idx  <= 3'd0;
         idx_vld    <= 1'b0;
         rev_pulse  <= 1'b0;
         err_pulse  <= 1'b0;
         rev_cnt    <= '0;
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (in_vld) phase_idx <= in_idx;
         idx_vld   <= in_vld;
         rev_pulse <= rev_ev;
         err_pulse <= err_ev;
         if (clr) begin
            rev_cnt    <= rev_ev ? REV_W'(1) : '0;
            err_cnt    <= err_ev ? ERR_W'(1) : '0;
            err_sticky <= err_ev;
         end else begin
            if (rev_ev) rev_cnt <= rev_cnt + REV_W'(1);
            if (err_ev && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
            if (err_ev) err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomized bench for johnson_phase_monitor: two instances (8-bit and 2-bit
// counters) share stimulus and are compared against a run-length reference model.
module tb_johnson_phase_monitor;

   localparam int LOCK_CNT = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] phase_in;
   logic       clr;

   logic [2:0] w_idx, n_idx;
   logic       w_vld, n_vld, w_locked, n_locked;
   logic       w_rev_p, n_rev_p, w_err_p, n_err_p, w_sticky, n_sticky;
   logic [7:0] w_rev, w_err;
   logic [1:0] n_rev, n_err;

   int pass_cnt = 0;
   int check_cnt = 0;

   // reference model state
   logic [7:0] m_prev;
   int         m_run;
   logic [2:0] m_idx;
   logic       m_vld, m_locked, m_rev_p, m_err_p, m_sticky;
   int         m_revw, m_revn, m_errw, m_errn;

   always #5 clk = ~clk;

   johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(8), .ERR_W(8)) dut (
      .clk(clk), .rstn(rstn), .phase_in(phase_in), .clr(clr),
      .phase_idx(w_idx), .idx_vld(w_vld), .locked(w_locked),
      .rev_pulse(w_rev_p), .rev_cnt(w_rev), .err_pulse(w_err_p),
      .err_sticky(w_sticky), .err_cnt(w_err)
   );

   johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(2), .ERR_W(2)) dut_n (
      .clk(clk), .rstn(rstn), .phase_in(phase_in), .clr(clr),
      .phase_idx(n_idx), .idx_vld(n_vld), .locked(n_locked),
      .rev_pulse(n_rev_p), .rev_cnt(n_rev), .err_pulse(n_err_p),
      .err_sticky(n_sticky), .err_cnt(n_err)
   );

   task automatic checkResult(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // position of the set bit counted from the MSB, or -1 when not exactly one-hot
   function automatic int idxOf(input logic [7:0] w);
      for (int i = 0; i < 8; i++) if (w == (8'h80 >> i)) return i;
      return -1;
   endfunction

   task automatic modelReset();
      m_prev = 8'h00; m_run = 0; m_idx = 3'd0; m_vld = 0; m_locked = 0;
      m_rev_p = 0; m_err_p = 0; m_sticky = 0;
      m_revw = 0; m_revn = 0; m_errw = 0; m_errn = 0;
   endtask

   // lock means the last LOCK_CNT (or more) steps were all good steps
   task automatic modelStep(input logic [7:0] w, input logic c);
      int  pi, ci;
      bit  good, was_locked;
      pi = idxOf(m_prev);
      ci = idxOf(w);
      good = (pi >= 0) && (ci >= 0) && (ci == (pi + 1) % 8);
      was_locked = m_locked;
      m_rev_p = was_locked && good && (ci == 0);
      m_err_p = was_locked && !good;
      m_run = good ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      m_locked = (m_run >= LOCK_CNT);
      m_vld = (ci >= 0);
      if (ci >= 0) m_idx = 3'(ci);
      if (c) begin
         m_revw = m_rev_p ? 1 : 0;  m_revn = m_revw;
         m_errw = m_err_p ? 1 : 0;  m_errn = m_errw;
         m_sticky = m_err_p;
      end else begin
         m_revw = (m_revw + int'(m_rev_p)) % 256;
         m_revn = (m_revn + int'(m_rev_p)) % 4;
         if (m_err_p) begin
            if (m_errw < 255) m_errw++;
            if (m_errn < 3) m_errn++;
            m_sticky = 1;
         end
      end
      m_prev = w;
   endtask

   task automatic checkOutput();
      checkResult("phase_idx", 32'(w_idx), 32'(m_idx));
      checkResult("idx_vld", 32'(w_vld), 32'(m_vld));
      checkResult("locked", 32'(w_locked), 32'(m_locked));
      checkResult("rev_pulse", 32'(w_rev_p), 32'(m_rev_p));
      checkResult("err_pulse", 32'(w_err_p), 32'(m_err_p));
      checkResult("err_sticky", 32'(w_sticky), 32'(m_sticky));
      checkResult("rev_cnt", 32'(w_rev), 32'(m_revw));
      checkResult("err_cnt", 32'(w_err), 32'(m_errw));
      checkResult("n_locked", 32'(n_locked), 32'(m_locked));
      checkResult("n_err_pulse", 32'(n_err_p), 32'(m_err_p));
      checkResult("n_rev_cnt", 32'(n_rev), 32'(m_revn));
      checkResult("n_err_cnt", 32'(n_err), 32'(m_errn));
   endtask

   task automatic checkAllZero(input string tag);
      checkResult({tag, "_w"}, {16'h0, w_idx, w_vld, w_locked, w_rev_p, w_err_p, w_sticky, w_rev}, 32'h0);
      checkResult({tag, "_werr"}, 32'(w_err), 32'h0);
      checkResult({tag, "_n"}, {21'h0, n_idx, n_vld, n_locked, n_rev_p, n_err_p, n_sticky, n_rev, n_err}, 32'h0);
   endtask

   task automatic applyStimulus(input logic [7:0] w, input logic c);
      phase_in = w;
      clr = c;
      @(posedge clk);
      #1;
      modelStep(w, c);
      checkOutput();
   endtask

   task automatic doAsyncReset();
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checkAllZero("async_reset");
      modelReset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   logic [7:0] directed_w [$];
   logic       directed_c [$];
   logic [7:0] drv_last;

   initial begin
      logic [7:0] w, nxt;
      logic       c;
      int         r, a, b, di;

      rstn = 1'b0; phase_in = 8'h00; clr = 1'b0;
      modelReset();
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rstn = 1'b1;

      // acquisition plus two revolutions, a mis-step while locked, re-lock,
      // clr colliding with an error, clr alone, then invalid words while locked
      directed_w = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                     8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h20, 8'h10, 8'h08, 8'h04,
                     8'h02, 8'h01, 8'h80, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                     8'h02, 8'h01, 8'h00, 8'h81, 8'h80};
      directed_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 1, 0, 0, 0, 0, 1,
                     0, 0, 0, 0, 0};
      for (di = 0; di < directed_w.size(); di++) applyStimulus(directed_w[di], directed_c[di]);
      drv_last = 8'h80;

      for (int n = 0; n < 2000; n++) begin
         r = $urandom_range(0, 99);
         nxt = (idxOf(drv_last) >= 0) ? (8'h80 >> ((idxOf(drv_last) + 1) % 8)) : 8'h80;
         if (r < 82) w = nxt;
         else if (r < 86) w = drv_last;
         else if (r < 90) w = 8'h00;
         else if (r < 94) begin
            a = $urandom_range(0, 7);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            w = (8'h01 << a) | (8'h01 << b);
         end else w = 8'h01 << $urandom_range(0, 7);
         c = ($urandom_range(0, 99) < 3);
         applyStimulus(w, c);
         drv_last = w;
         if (n == 1000) begin
            doAsyncReset();
            drv_last = 8'h00;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
